// File: rtl/fnd_scan_ctrl_if.sv
// Signal bundle between the HH:MM:SS display logic and the FND scan controller.
// The master drives the digit data and controls; the slave (scan controller)
// returns the decoder nibble, digit commons and frame timing.
interface fnd_scan_ctrl_if;
    logic        i_en;
    logic [23:0] i_digits;
    logic [5:0]  i_blink_mask;
    logic [3:0]  o_num;
    logic [5:0]  o_com;
    logic [2:0]  o_digit_idx;
    logic        o_frame_tick;

    modport master (
        output i_en,
        output i_digits,
        output i_blink_mask,
        input  o_num,
        input  o_com,
        input  o_digit_idx,
        input  o_frame_tick
    );

    modport slave (
        input  i_en,
        input  i_digits,
        input  i_blink_mask,
        output o_num,
        output o_com,
        output o_digit_idx,
        output o_frame_tick
    );
endinterface

// File: rtl/fnd_scan_ctrl.sv
// Six-digit time-multiplexed 7-segment scan controller.
// Each slot shows one BCD nibble through the shared decoder (o_num) and pulls
// one active-low common low after a short guard interval to avoid ghosting.
// Digits flagged in the blink mask are blanked for whole slots during the
// "off" half of the blink period; the blink phase is latched once per frame.
module fnd_scan_ctrl #(
    parameter int unsigned SCAN_DIV   = 5000,
    parameter int unsigned GUARD      = 250,
    parameter int unsigned BLINK_HALF = 25000000
) (
    input  logic           clk,
    input  logic           rst_n,
    fnd_scan_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = ($clog2(SCAN_DIV) > 0) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLK_W = ($clog2(BLINK_HALF) > 0) ? $clog2(BLINK_HALF) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_C  = CNT_W'(GUARD);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_HALF - 1);
    localparam logic [2:0]       IDX_LAST = 3'd5;

    // ST_IDLE: disabled or just out of reset; the next enabled edge opens slot 0.
    // ST_SCAN: cycling through the six digit slots.
    typedef enum logic [0:0] {
        ST_IDLE,
        ST_SCAN
    } state_t;

    state_t           r_state,     w_state_next;
    logic [CNT_W-1:0] r_cnt,       w_cnt_next;
    logic [2:0]       r_idx,       w_idx_next;
    logic [BLK_W-1:0] r_blk_cnt,   w_blk_cnt_next;
    logic             r_blink_ph,  w_blink_ph_next;
    logic             r_frame_ph,  w_frame_ph_next;
    logic             r_blank,     w_blank_next;
    logic [3:0]       r_num,       w_num_next;
    logic [5:0]       r_com,       w_com_next;
    logic             r_tick,      w_tick_next;
    logic             w_slot_start;

    function automatic logic [3:0] nibble_sel(input logic [23:0] digits,
                                              input logic [2:0]  idx);
        case (idx)
            3'd0:    return digits[3:0];
            3'd1:    return digits[7:4];
            3'd2:    return digits[11:8];
            3'd3:    return digits[15:12];
            3'd4:    return digits[19:16];
            3'd5:    return digits[23:20];
            default: return 4'hF;
        endcase
    endfunction

    // State and output registers; reset forces all commons off and a blank nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_blk_cnt  <= '0;
            r_blink_ph <= 1'b0;
            r_frame_ph <= 1'b0;
            r_blank    <= 1'b0;
            r_num      <= 4'hF;
            r_com      <= '1;
            r_tick     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_idx      <= w_idx_next;
            r_blk_cnt  <= w_blk_cnt_next;
            r_blink_ph <= w_blink_ph_next;
            r_frame_ph <= w_frame_ph_next;
            r_blank    <= w_blank_next;
            r_num      <= w_num_next;
            r_com      <= w_com_next;
            r_tick     <= w_tick_next;
        end
    end

    // Next-state logic: slot/blink counters, slot-start loading and the
    // registered common pattern for the cycle after this edge.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_idx_next      = r_idx;
        w_blk_cnt_next  = r_blk_cnt;
        w_blink_ph_next = r_blink_ph;
        w_frame_ph_next = r_frame_ph;
        w_blank_next    = r_blank;
        w_num_next      = r_num;
        w_com_next      = '1;
        w_tick_next     = 1'b0;
        w_slot_start    = 1'b0;

        if (!bus.i_en) begin
            w_state_next    = ST_IDLE;
            w_cnt_next      = '0;
            w_idx_next      = '0;
            w_blk_cnt_next  = '0;
            w_blink_ph_next = 1'b0;
            w_frame_ph_next = 1'b0;
            w_blank_next    = 1'b0;
            w_num_next      = 4'hF;
        end else begin
            w_state_next = ST_SCAN;

            if (r_blk_cnt == BLK_LAST) begin
                w_blk_cnt_next  = '0;
                w_blink_ph_next = ~r_blink_ph;
            end else begin
                w_blk_cnt_next = r_blk_cnt + 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    w_slot_start = 1'b1;
                    w_cnt_next   = '0;
                    w_idx_next   = '0;
                end
                ST_SCAN: begin
                    if (r_cnt == CNT_LAST) begin
                        w_slot_start = 1'b1;
                        w_cnt_next   = '0;
                        w_idx_next   = (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase

            // Frame phase uses the blink phase as it stood before this edge,
            // so the whole frame sees one consistent blink decision.
            if (w_slot_start) begin
                if (w_idx_next == 3'd0) begin
                    w_frame_ph_next = r_blink_ph;
                    w_tick_next     = 1'b1;
                end
                w_blank_next = w_frame_ph_next & bus.i_blink_mask[w_idx_next];
                w_num_next   = w_blank_next ? 4'hF
                                            : nibble_sel(bus.i_digits, w_idx_next);
            end

            if (!w_blank_next && (w_cnt_next >= GUARD_C)) begin
                w_com_next = ~(6'b000001 << w_idx_next);
            end
        end
    end

    assign bus.o_num        = r_num;
    assign bus.o_com        = r_com;
    assign bus.o_digit_idx  = r_idx;
    assign bus.o_frame_tick = r_tick;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Scoreboard bench for fnd_scan_ctrl (SCAN_DIV=8, GUARD=2, BLINK_HALF=96).
// The stimulus process pushes the expected post-edge output for each checked
// cycle; a negedge monitor pops and compares.
module tb_fnd_scan_ctrl;

    localparam int SD    = 8;
    localparam int GD    = 2;
    localparam int BH    = 96;
    localparam int FRAME = SD * 6;

    logic clk = 1'b0;
    logic rst_n;

    fnd_scan_ctrl_if bus();

    fnd_scan_ctrl #(
        .SCAN_DIV   (SD),
        .GUARD      (GD),
        .BLINK_HALF (BH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] num;
        logic [5:0] com;
        logic [2:0] idx;
        logic       tick;
        int         scen;
        int         cyc;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   checks = 0;
    int   errors = 0;
    int   scen   = 0;

    // Expected output t cycles after the first enabled edge, with dg/mk the
    // digit word and blink mask in effect at the relevant slot start.
    function automatic exp_t scan_exp(input logic [23:0] dg, input logic [5:0] mk,
                                      input int t, input int sc);
        exp_t e;
        int s, c, f;
        logic blank;
        s = (t / SD) % 6;
        c = t % SD;
        f = t / FRAME;
        blank = (((f * FRAME / BH) % 2) == 1) && mk[s];
        e.num  = blank ? 4'hF : dg[4*s +: 4];
        e.com  = (blank || c < GD) ? 6'h3F : ~(6'b000001 << s);
        e.idx  = 3'(s);
        e.tick = ((t % FRAME) == 0);
        e.scen = sc;
        e.cyc  = t;
        return e;
    endfunction

    task automatic push_idle(input int c);
        exp_t e;
        e.num = 4'hF; e.com = 6'h3F; e.idx = 3'd0; e.tick = 1'b0;
        e.scen = scen; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic cyc(input logic [23:0] dg, input logic [5:0] mk, input int t);
        @(posedge clk); #1;
        q.push_back(scan_exp(dg, mk, t, scen));
    endtask

    // Called 1 time unit after a posedge whose result has not been queued.
    // The first check lands before the next posedge, so it sees the async clear.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        push_idle(-1);
        repeat (2) begin
            @(posedge clk); #1;
            push_idle(-1);
        end
        rst_n = 1'b1;
        bus.i_en = 1'b1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            checks++;
            if (bus.o_num !== m_e.num || bus.o_com !== m_e.com ||
                bus.o_digit_idx !== m_e.idx || bus.o_frame_tick !== m_e.tick) begin
                errors++;
                $display("FAIL scen%0d cyc%0d: got num=%h com=%b idx=%0d tick=%b, expected num=%h com=%b idx=%0d tick=%b",
                         m_e.scen, m_e.cyc, bus.o_num, bus.o_com, bus.o_digit_idx,
                         bus.o_frame_tick, m_e.num, m_e.com, m_e.idx, m_e.tick);
            end
        end
        checks++;
        if ($countones(~bus.o_com) > 1) begin
            errors++;
            $display("FAIL onehot: o_com=%b, expected at most one bit low", bus.o_com);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n            = 1'b0;
        bus.i_en         = 1'b0;
        bus.i_digits     = 24'h123456;
        bus.i_blink_mask = 6'b000000;
        @(posedge clk); #1;

        // Reset then scan of 123456; free run for frame-tick period.
        scen = 1;
        bus.i_en = 1'b1;
        do_reset();
        for (int t = 0; t < FRAME; t++) cyc(24'h123456, 6'b000000, t);
        scen = 2;
        for (int t = FRAME; t < 3 * FRAME; t++) cyc(24'h123456, 6'b000000, t);

        // Blink digits 0 and 1 across eight frames.
        scen = 3;
        @(posedge clk); #1;
        bus.i_blink_mask = 6'b000011;
        do_reset();
        for (int t = 0; t < 8 * FRAME; t++) cyc(24'h123456, 6'b000011, t);

        // Mid-slot digit change only appears at the next slot 0.
        scen = 4;
        @(posedge clk); #1;
        bus.i_blink_mask = 6'b000000;
        do_reset();
        for (int t = 0; t < 2 * FRAME; t++) begin
            cyc((t < FRAME) ? 24'h123456 : 24'h123459, 6'b000000, t);
            if (t == 3) bus.i_digits = 24'h123459;
        end

        // Disable for 10 cycles in the middle of slot 2, then re-enable.
        scen = 5;
        @(posedge clk); #1;
        bus.i_digits = 24'h123456;
        do_reset();
        for (int t = 0; t < 2 * SD + 6; t++) cyc(24'h123456, 6'b000000, t);
        bus.i_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            push_idle(i);
        end
        bus.i_en = 1'b1;
        for (int t = 0; t < 7 * SD; t++) cyc(24'h123456, 6'b000000, t);

        // Asynchronous reset while slot 4 has its common low.
        scen = 6;
        @(posedge clk); #1;
        do_reset();
        for (int t = 0; t < 4 * SD + 3; t++) cyc(24'h123456, 6'b000000, t);
        @(posedge clk); #1;
        do_reset();
        for (int t = 0; t < FRAME; t++) cyc(24'h123456, 6'b000000, t);

        for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
